// File: rtl/fpu_mul_seq_pkg.sv
// Shared types and constants for the FPU multiply pipeline sequencer.
package fpu_mul_seq_pkg;

   localparam int unsigned MUL_STAGES   = 6;
   localparam int unsigned MUL_TAG_W    = 5;
   localparam int unsigned CLKEN_HOLD_W = 4;

   localparam int unsigned M1 = 0;
   localparam int unsigned M2 = 1;
   localparam int unsigned M3 = 2;
   localparam int unsigned M4 = 3;
   localparam int unsigned M5 = 4;
   localparam int unsigned M6 = 5;

   typedef struct packed {
      logic                 vld;
      logic                 dbl;
      logic [MUL_TAG_W-1:0] tag;
   } stage_t;

endpackage

// File: rtl/fpu_mul_clken_hold.sv
// Keeps the multiply pipe clock enabled while work is pending and for
// CLKEN_HOLD cycles after the pipe drains.
module fpu_mul_clken_hold
   import fpu_mul_seq_pkg::*;
#(
   parameter int unsigned CLKEN_HOLD = 3
) (
   input  logic rclk,
   input  logic arst_l,
   input  logic pipe_busy,
   input  logic req,
   output logic fmul_clken_l
);

   logic [CLKEN_HOLD_W-1:0] hold_q;

   // Reloaded on every busy edge, so the value seen after the drain edge is CLKEN_HOLD.
   always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
         hold_q <= '0;
      end else if (pipe_busy) begin
         hold_q <= CLKEN_HOLD_W'(CLKEN_HOLD);
      end else if (hold_q != '0) begin
         hold_q <= hold_q - CLKEN_HOLD_W'(1);
      end
   end

   assign fmul_clken_l = ~(req | pipe_busy | (hold_q != '0));

endmodule

// File: rtl/fpu_mul_pipe_seq.sv
// Multiply pipeline sequencer: tracks valid/precision/tag through m1..m6,
// generates the pipe step, precision decodes and the pipe clock enable.
module fpu_mul_pipe_seq
   import fpu_mul_seq_pkg::*;
#(
   parameter int unsigned TAG_W      = MUL_TAG_W,
   parameter int unsigned CLKEN_HOLD = 3
) (
   input  logic                  rclk,
   input  logic                  arst_l,
   input  logic                  inq_mul_vld,
   input  logic                  inq_mul_dbl,
   input  logic [TAG_W-1:0]      inq_mul_tag,
   output logic                  mul_inq_rdy,
   input  logic                  mul_flush,
   input  logic                  arb_mul_rdy,
   output logic                  mul_out_vld,
   output logic [TAG_W-1:0]      mul_out_tag,
   output logic                  mul_out_dbl,
   output logic                  m6stg_step,
   output logic                  m1stg_dblop,
   output logic                  m1stg_dblop_inv,
   output logic                  m5stg_fmuls,
   output logic                  m5stg_fmulda,
   output logic [MUL_STAGES-1:0] mul_stg_vld,
   output logic                  fmul_clken_l
);

   stage_t                  stage_q [MUL_STAGES];
   stage_t                  in_stage;
   logic [MUL_STAGES-1:0]   vld_c;
   logic                    accept;
   logic                    pipe_busy;
   logic                    clk_en_lat;
   logic                    gclk;

   always_comb begin
      vld_c = '0;
      for (int k = 0; k < MUL_STAGES; k++) begin
         vld_c[k] = stage_q[k].vld;
      end
   end

   assign pipe_busy   = |vld_c;
   assign m6stg_step  = ~(stage_q[M6].vld & ~arb_mul_rdy) | mul_flush;
   assign mul_inq_rdy = m6stg_step & ~mul_flush;
   assign accept      = inq_mul_vld & mul_inq_rdy;

   always_comb begin
      in_stage     = '0;
      in_stage.vld = accept;
      in_stage.dbl = inq_mul_dbl;
      in_stage.tag = MUL_TAG_W'(inq_mul_tag);
   end

   // Glitch-free gate: enable is captured while rclk is low.
   always_latch begin
      if (!rclk) begin
         clk_en_lat <= ~fmul_clken_l;
      end
   end

   assign gclk = rclk & clk_en_lat;

   // Whole pipe advances together; flush only kills validity.
   always_ff @(posedge gclk or negedge arst_l) begin
      if (!arst_l) begin
         for (int k = 0; k < MUL_STAGES; k++) begin
            stage_q[k] <= '0;
         end
      end else if (mul_flush) begin
         for (int k = 0; k < MUL_STAGES; k++) begin
            stage_q[k].vld <= 1'b0;
         end
      end else if (m6stg_step) begin
         stage_q[M1] <= in_stage;
         stage_q[M2] <= stage_q[M1];
         stage_q[M3] <= stage_q[M2];
         stage_q[M4] <= stage_q[M3];
         stage_q[M5] <= stage_q[M4];
         stage_q[M6] <= stage_q[M5];
      end
   end

   assign mul_out_vld     = stage_q[M6].vld;
   assign mul_out_tag     = TAG_W'(stage_q[M6].tag);
   assign mul_out_dbl     = stage_q[M6].dbl;
   assign mul_stg_vld     = vld_c;
   assign m1stg_dblop     = stage_q[M1].vld & stage_q[M1].dbl;
   assign m1stg_dblop_inv = ~m1stg_dblop;
   assign m5stg_fmuls     = stage_q[M5].vld & ~stage_q[M5].dbl;
   assign m5stg_fmulda    = stage_q[M5].vld & stage_q[M5].dbl;

   fpu_mul_clken_hold #(
      .CLKEN_HOLD (CLKEN_HOLD)
   ) u_clken_hold (
      .rclk         (rclk),
      .arst_l       (arst_l),
      .pipe_busy    (pipe_busy),
      .req          (inq_mul_vld),
      .fmul_clken_l (fmul_clken_l)
   );

endmodule

// File: tb/tb_fpu_mul_pipe_seq.sv
// Randomized bench for fpu_mul_pipe_seq against an op-queue reference model.
module tb_fpu_mul_pipe_seq;

   localparam int unsigned TW   = 5;
   localparam int          HOLD = 3;

   logic          rclk, arst_l;
   logic          inq_mul_vld, inq_mul_dbl, mul_flush, arb_mul_rdy;
   logic [TW-1:0] inq_mul_tag;
   logic          mul_inq_rdy, mul_out_vld, mul_out_dbl, m6stg_step;
   logic          m1stg_dblop, m1stg_dblop_inv, m5stg_fmuls, m5stg_fmulda;
   logic [TW-1:0] mul_out_tag;
   logic [5:0]    mul_stg_vld;
   logic          fmul_clken_l;

   fpu_mul_pipe_seq #(.TAG_W(TW), .CLKEN_HOLD(HOLD)) dut (
      .rclk            (rclk),
      .arst_l          (arst_l),
      .inq_mul_vld     (inq_mul_vld),
      .inq_mul_dbl     (inq_mul_dbl),
      .inq_mul_tag     (inq_mul_tag),
      .mul_inq_rdy     (mul_inq_rdy),
      .mul_flush       (mul_flush),
      .arb_mul_rdy     (arb_mul_rdy),
      .mul_out_vld     (mul_out_vld),
      .mul_out_tag     (mul_out_tag),
      .mul_out_dbl     (mul_out_dbl),
      .m6stg_step      (m6stg_step),
      .m1stg_dblop     (m1stg_dblop),
      .m1stg_dblop_inv (m1stg_dblop_inv),
      .m5stg_fmuls     (m5stg_fmuls),
      .m5stg_fmulda    (m5stg_fmulda),
      .mul_stg_vld     (mul_stg_vld),
      .fmul_clken_l    (fmul_clken_l)
   );

   initial begin
      rclk = 1'b0;
      forever #5 rclk = ~rclk;
   end

   // Each in-flight op knows its stage index (0 = m1); oldest at the front.
   typedef struct {
      int          pos;
      bit          dbl;
      bit [TW-1:0] tag;
   } op_t;

   op_t pipe_q[$];
   int  cyc, last_busy, checks, errors;
   bit  s_out_vld, s_clken_l, s_m5d;
   bit [TW-1:0] s_out_tag;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic bit head_in_m6();
      return (pipe_q.size() > 0) && (pipe_q[0].pos == 5);
   endfunction

   task automatic check_outputs();
      bit          e_vld6, e_dbl6, e_m1d, e_m5s, e_m5d, e_step, e_rdy, e_clkl;
      bit [TW-1:0] e_tag6;
      bit [5:0]    e_stg;
      e_vld6 = 0; e_dbl6 = 0; e_m1d = 0; e_m5s = 0; e_m5d = 0; e_tag6 = '0; e_stg = '0;
      foreach (pipe_q[i]) begin
         e_stg[pipe_q[i].pos] = 1'b1;
         if (pipe_q[i].pos == 0) e_m1d = pipe_q[i].dbl;
         if (pipe_q[i].pos == 4) begin
            e_m5s = !pipe_q[i].dbl;
            e_m5d = pipe_q[i].dbl;
         end
         if (pipe_q[i].pos == 5) begin
            e_vld6 = 1'b1;
            e_dbl6 = pipe_q[i].dbl;
            e_tag6 = pipe_q[i].tag;
         end
      end
      e_step = !(e_vld6 && !arb_mul_rdy) || mul_flush;
      e_rdy  = e_step && !mul_flush;
      e_clkl = !(inq_mul_vld || pipe_q.size() > 0 || (cyc - last_busy <= HOLD));
      chk("stg_vld", 32'(mul_stg_vld), 32'(e_stg));
      chk("out_vld", 32'(mul_out_vld), 32'(e_vld6));
      chk("step", 32'(m6stg_step), 32'(e_step));
      chk("inq_rdy", 32'(mul_inq_rdy), 32'(e_rdy));
      chk("clken_l", 32'(fmul_clken_l), 32'(e_clkl));
      chk("m1_dbl", 32'(m1stg_dblop), 32'(e_m1d));
      chk("m1_dbl_inv", 32'(m1stg_dblop_inv), 32'(!e_m1d));
      chk("m5_fmuls", 32'(m5stg_fmuls), 32'(e_m5s));
      chk("m5_fmulda", 32'(m5stg_fmulda), 32'(e_m5d));
      if (e_vld6) begin
         chk("out_tag", 32'(mul_out_tag), 32'(e_tag6));
         chk("out_dbl", 32'(mul_out_dbl), 32'(e_dbl6));
      end
      s_out_vld = mul_out_vld;
      s_clken_l = fmul_clken_l;
      s_out_tag = mul_out_tag;
      s_m5d     = m5stg_fmulda;
   endtask

   // Model state update for the coming edge, using the inputs held across it.
   task automatic model_advance();
      if (arst_l) begin
         if (pipe_q.size() > 0) last_busy = cyc;
         if (mul_flush) begin
            pipe_q.delete();
         end else if (!(head_in_m6() && !arb_mul_rdy)) begin
            if (head_in_m6()) void'(pipe_q.pop_front());
            foreach (pipe_q[i]) pipe_q[i].pos++;
            if (inq_mul_vld) pipe_q.push_back('{pos: 0, dbl: inq_mul_dbl, tag: inq_mul_tag});
         end
      end
      cyc++;
   endtask

   task automatic run_cycle();
      @(negedge rclk);
      check_outputs();
      model_advance();
      @(posedge rclk);
      #1;
   endtask

   task automatic drive(input bit v, input bit d, input bit [TW-1:0] t, input bit a, input bit f);
      inq_mul_vld = v; inq_mul_dbl = d; inq_mul_tag = t; arb_mul_rdy = a; mul_flush = f;
   endtask

   task automatic assert_reset();
      drive(0, 0, '0, 1, 0);
      arst_l    = 1'b0;
      pipe_q.delete();
      last_busy = -100;
   endtask

   // One fmuld with tag 5 from an idle pipe: latency 6, clock gate off 10 cycles after accept.
   task automatic single_op_test();
      int first_out, first_off, n_out;
      first_out = -1; first_off = -1; n_out = 0;
      drive(1, 1, TW'(5), 1, 0);
      run_cycle();
      drive(0, 0, '0, 1, 0);
      for (int r = 1; r <= 11; r++) begin
         run_cycle();
         if (s_out_vld) begin
            n_out++;
            if (first_out < 0) first_out = r;
            chk("single_tag", 32'(s_out_tag), 32'd5);
         end
         if (r == 5) chk("single_m5d", 32'(s_m5d), 32'd1);
         if (s_clken_l && first_off < 0) first_off = r;
      end
      chk("single_latency", 32'(first_out), 32'd6);
      chk("single_count", 32'(n_out), 32'd1);
      chk("single_clkoff", 32'(first_off), 32'd10);
   endtask

   task automatic random_phase(input int n, input int p_vld, input int p_arb, input int p_flush,
                               input int rst_at);
      for (int i = 0; i < n; i++) begin
         if (i == rst_at) begin
            assert_reset();
            run_cycle();
            run_cycle();
            arst_l = 1'b1;
            single_op_test();
         end
         drive($urandom_range(99) < 32'(p_vld), 1'($urandom), TW'($urandom),
               $urandom_range(99) < 32'(p_arb), $urandom_range(99) < 32'(p_flush));
         run_cycle();
      end
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0;
      arst_l = 1'b0;
      assert_reset();
      #2;
      run_cycle();
      run_cycle();
      arst_l = 1'b1;
      single_op_test();
      random_phase(300, 100, 100, 0, -1);
      random_phase(300, 70, 40, 2, -1);
      random_phase(300, 50, 60, 4, 150);
      random_phase(300, 15, 80, 1, -1);
      drive(0, 0, '0, 1, 0);
      for (int i = 0; i < 15; i++) run_cycle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpu_mul_pipe_seq.md
Name: fpu_mul_pipe_seq

Overview:
- Sequencer for the FPU multiply pipeline fraction/exponent datapath.
- Accepts one multiply op per cycle from the FPU input queue and tracks validity, op type and tag through stages m1..m6.
- Generates the pipe advance (m6stg_step), stage-1/stage-5 precision selects, and the active-low pipe clock enable.
- Holds the m6 result until the FPU output arbiter accepts it.

Parameters:
- TAG_W, 5, width of request tag carried with each op.
- CLKEN_HOLD, 3, cycles the pipe clock stays enabled after the pipe drains (1..15).

Ports:
- rclk  in  1  clock
- arst_l  in  1  asynchronous active-low reset
- inq_mul_vld  in  1  input queue presents a multiply op
- inq_mul_dbl  in  1  op is fmuld (0 = fmuls)
- inq_mul_tag  in  TAG_W  request tag
- mul_inq_rdy  out  1  op accepted this cycle when inq_mul_vld=1
- mul_flush  in  1  kill all in-flight ops (trap/reset of unit)
- arb_mul_rdy  in  1  output arbiter accepts the m6 result
- mul_out_vld  out  1  m6 result valid
- mul_out_tag  out  TAG_W  tag of m6 result
- mul_out_dbl  out  1  precision of m6 result
- m6stg_step  out  1  advance multiply pipe
- m1stg_dblop  out  1  m1 op is double
- m1stg_dblop_inv  out  1  complement of m1stg_dblop
- m5stg_fmuls  out  1  valid single op in m5
- m5stg_fmulda  out  1  valid double op in m5
- mul_stg_vld  out  6  valid bits m1..m6 (bit0 = m1)
- fmul_clken_l  out  1  pipe clock enable, active low

Behaviour:
- Reset (arst_l=0, async): all stage valids/dbl bits/tags = 0, hold counter = 0. Outputs: mul_out_vld=0, mul_out_tag=0, mul_out_dbl=0, mul_stg_vld=0, m5stg_fmuls=0, m5stg_fmulda=0, m1stg_dblop=0, m1stg_dblop_inv=1, m6stg_step=1, mul_inq_rdy=1 (when not flushing), fmul_clken_l=1.
- Step rule (combinational): m6stg_step = ~(vld[6] & ~arb_mul_rdy) | mul_flush.
- Stall: all stages freeze together, no bubble compression.
- Accept: mul_inq_rdy = m6stg_step & ~mul_flush.
- Accept on edge when inq_mul_vld & mul_inq_rdy: vld[1]<=1, dbl[1]<=inq_mul_dbl, tag[1]<=inq_mul_tag.
- On a step with no accept: vld[1]<=0.
- On step: stage k+1 <= stage k for k=1..5; vld[6] is overwritten by vld[5].
- Latency: an op accepted at edge t is in m1 in cycle t+1 and presents mul_out_vld in cycle t+6 with no stalls. Each stall cycle adds 1. Throughput 1 op/cycle.
- Output handshake: the result retires on an edge with mul_out_vld & arb_mul_rdy. Simultaneous retire and refill of m6 from m5 is allowed. mul_out_tag and mul_out_dbl are stable while mul_out_vld=1 and arb_mul_rdy=0.
- Flush: mul_flush=1 clears every vld at the next edge and blocks accept in the same cycle. Tags/dbl bits need not clear. mul_out_vld drops the cycle after. A flush concurrent with a stall still clears.
- Decodes: m1stg_dblop = vld[1] & dbl[1]; m5stg_fmuls = vld[5] & ~dbl[5]; m5stg_fmulda = vld[5] & dbl[5].
- Clock gating: fmul_clken_l = ~(inq_mul_vld | (|vld) | (hold_cnt != 0)).
- Hold counter: loads CLKEN_HOLD on the edge where |vld goes 1->0 (including by flush). Otherwise decrements to 0 and saturates. It reloads if the pipe refills and drains again.
- The clock-enable logic runs on ungated rclk; the datapath registers use the gated clock.

Decomposition:
- Shared package fpu_mul_seq_pkg: MUL_STAGES=6, TAG_W default, stage index constants M1..M6, struct/typedef for stage entry {vld, dbl, tag}.
- Sub-module fpu_mul_clken_hold: hold down-counter plus fmul_clken_l generation; inputs pipe_busy and req, parameter CLKEN_HOLD.

Test Plan:
- Single fmuld, tag=5, arb_mul_rdy=1, accept at edge 0 -> m5stg_fmulda=1 in cycle 5; mul_out_vld=1, tag=5, dbl=1 in cycle 6 only; fmul_clken_l returns to 1 in cycle 10 (hold 3).
- Back-to-back 8 ops, alternating sng/dbl, tags 0..7, arb always ready -> mul_out_vld high cycles 6..13, tags 0..7 in order, m5stg_fmuls/fmulda alternate cycles 5..12.
- 3 ops, arb_mul_rdy=0 from cycle 6 for 4 cycles -> m6stg_step=0 and mul_inq_rdy=0 cycles 6..9; tag 0 held; tags 1,2 delivered cycles 11,12; nothing lost or duplicated.
- Stalled m6 plus m5 valid, arb_mul_rdy rises same cycle as new inq_mul_vld -> retire, shift and accept all on one edge; mul_stg_vld correct next cycle.
- 4 in-flight ops, mul_flush pulse at cycle 3 with inq_mul_vld=1 -> mul_inq_rdy=0 that cycle; mul_stg_vld=0 cycle 4; no mul_out_vld ever; clken_l=1 at cycle 7.
- arst_l asserted mid-stream (cycle 4, async, between edges) -> all outputs take reset values immediately; after release a new op completes with 6-cycle latency.
